sigma_delta_dac: RTL and testbench
==================================

# sigma_delta_dac

Digital front end of the DAC path, the output-side counterpart to the flash ADC macro: it accepts parallel PCM samples over a valid/ready handshake, buffers them in a small FIFO, and plays them out at a fixed sample rate. Each sample drives a first-order sigma-delta modulator that produces a 1-bit pulse-density stream. The stream goes to an analog pin, where an external RC low-pass reconstructs the level. The block sits between the digital sample source (SPI/test logic on `ui_in`/`uio_in`) and one analog/digital output pin.

## Interface
- `WIDTH`, default 8: sample width in bits.
- `OSR_LOG2`, default 5: log2 of the oversampling ratio. Clocks per sample period = 2^OSR_LOG2.
- `DEPTH_LOG2`, default 2: log2 of the FIFO depth (4 entries).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `en`  in  1  modulator enable. The FIFO keeps operating when `en` is low.
- `sample_in`  in  WIDTH  unsigned PCM sample.
- `sample_valid`  in  1  source has a sample on `sample_in`.
- `sample_ready`  out  1  FIFO can accept a sample (combinational from level).
- `dac_out`  out  1  registered pulse-density bitstream.
- `sample_tick`  out  1  one-cycle pulse at each sample-period boundary.
- `underrun`  out  1  one-cycle pulse when a tick finds the FIFO empty.
- `fifo_level`  out  DEPTH_LOG2+1  current number of FIFO entries.

## Operation
- **Push:** a push occurs when `sample_valid && sample_ready`. `sample_ready` = (`fifo_level` != 2^DEPTH_LOG2).
- **Divider:** `div` is an OSR_LOG2-bit counter.
  - It increments each cycle while `en`=1 and wraps at 2^OSR_LOG2-1.
  - `sample_tick`=1 in the cycle where `div`==all-ones and `en`=1.
- **Tick, FIFO non-empty:** pop the head into `cur`.
- **Tick, FIFO empty:** `cur` keeps its value and `underrun`=1 for that cycle.
- **No bypass:** a push in the same cycle as a tick on an empty FIFO is stored, is not used by that tick, and `underrun` still fires.
- **Push and pop in the same cycle:** `fifo_level` is unchanged. At full, `sample_ready`=0, so no push can coincide with the pop; the freed slot is visible next cycle.
- **Modulator:** `acc` is WIDTH bits; `sum` = {1'b0,`acc`} + {1'b0,`cur`} is WIDTH+1 bits.
  - Each enabled cycle: `acc` <= `sum`[WIDTH-1:0] and `dac_out` <= `sum`[WIDTH].
  - Ones density = `cur`/2^WIDTH exactly over any 2^WIDTH consecutive enabled cycles with constant `cur`.
  - `cur`=0 gives all zeros; `cur`=2^WIDTH-1 gives exactly one zero per 2^WIDTH cycles.
- **Disable:** when `en`=0, `div`, `acc` and `dac_out` are forced to 0 next cycle. `cur` and FIFO contents are retained, and pushes continue.
- **Reset:** all state is cleared asynchronously.
  - `div`=0, `acc`=0, `cur`=0, FIFO empty.
  - `dac_out`=0, `sample_tick`=0, `underrun`=0, `fifo_level`=0, `sample_ready`=1.
  - Reset mid-stream discards buffered samples; no flush.
- The FIFO uses wrapping read/write pointers of DEPTH_LOG2 bits plus a level counter. Pointer wrap is silent.

## Timing
- **Push latency:** `fifo_level` updates in the cycle after the push edge.
- **Tick to modulator:** the popped sample is loaded into `cur` at the tick edge. The first `dac_out` bit computed with it appears one cycle after that edge (registered output).
- **Empty-FIFO latency:** a sample pushed into an empty FIFO reaches `cur` at the next tick. That takes up to 2^OSR_LOG2 cycles, plus one cycle if pushed on a tick.
- **`sample_tick` period:** exactly 2^OSR_LOG2 cycles while `en`=1. The first tick after `en` rises or reset releases comes at enabled cycle 2^OSR_LOG2.
- **Output hazards:** `dac_out` comes straight from a flop, with no combinational path to the pin.

## Structure
- Shared package `dac_pkg`: default localparams for WIDTH, OSR_LOG2 and DEPTH_LOG2, and a function `clog2` if needed.
- One natural sub-module: `sample_fifo`, a parameterised synchronous FIFO with push/pop, level, full/empty flags and a registered head-data output.
- Divider and modulator stay inline in `sigma_delta_dac`.

## Test plan
- **Reset:** assert `rst` mid-cycle with 3 samples buffered → immediately `fifo_level`=0, `dac_out`=0, `sample_ready`=1. After release, no `underrun` until the first tick (cycle 32).
- **Density:** push 0x40 with `en`=1 → after the first tick, every 256-cycle window of `dac_out` has exactly 64 ones, in a pattern of one '1' every 4 cycles.
- **Extremes:** push 0x00 then 0xFF → the 0x00 period gives all zeros. The 0xFF period gives 255 ones per 256 cycles (check over 8 periods of OSR 5).
- **Full/backpressure:** hold `sample_valid` high with 5 samples → 4 accepted and `sample_ready`=0. At the tick, one is popped; `sample_ready` returns to 1 in the next cycle and the 5th sample is accepted.
- **Underrun:** empty FIFO with `cur`=0x80 → at each tick, `underrun`=1 and `cur` stays 0x80 (density 50%). A push on the tick cycle still raises `underrun`, and the pushed sample loads at the following tick.
- **Enable toggle:** drop `en` for 10 cycles → `dac_out`=0 and `sample_tick` absent; pushes are still accepted. After re-enable, the first tick is 32 cycles later, with the FIFO order preserved.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared defaults for the sigma-delta DAC front end.
//   DEF_WIDTH      : PCM sample width in bits
//   DEF_OSR_LOG2   : log2 of clocks per sample period
//   DEF_DEPTH_LOG2 : log2 of sample FIFO depth
package dac_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_OSR_LOG2   = 5;
    localparam int unsigned DEF_DEPTH_LOG2 = 2;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO for PCM samples with a registered head-data output.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push, data_in : write request and data (ignored when full)
//   pop           : read request (ignored when empty); head advances next cycle
//   head          : registered copy of the oldest entry
//   level         : number of stored entries
//   full_c        : combinational full flag
//   empty_c       : combinational empty flag
module sample_fifo
    import dac_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full_c,
    output logic                  empty_c
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam int unsigned PTR_W = DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;

    assign full_c     = (level == LVL_W'(DEPTH));
    assign empty_c    = (level == '0);
    assign do_push    = push && !full_c;
    assign do_pop     = pop && !empty_c;
    assign rd_ptr_nxt = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    // Storage and wrapping write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= wr_ptr + PTR_W'(1);
        end
    end

    // Read pointer and level counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Head register tracks the next oldest entry; forward the incoming
    // write when it lands exactly on the slot that becomes the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
        end else if (do_push && (wr_ptr == rd_ptr_nxt)) begin
            head <= data_in;
        end else begin
            head <= mem[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta DAC front end: buffers PCM samples, plays one
// per sample period, and emits a 1-bit pulse-density stream.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   en                        : modulator/divider enable (FIFO always runs)
//   sample_in, sample_valid   : incoming PCM sample and its valid
//   sample_ready              : FIFO not full (combinational)
//   dac_out                   : registered pulse-density bit
//   sample_tick               : sample-period boundary pulse
//   underrun                  : tick found the FIFO empty
//   fifo_level                : FIFO occupancy
module sigma_delta_dac
    import dac_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned OSR_LOG2   = DEF_OSR_LOG2,
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WIDTH-1:0]      sample_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  dac_out,
    output logic                  sample_tick,
    output logic                  underrun,
    output logic [DEPTH_LOG2:0]   fifo_level
);

    logic [OSR_LOG2-1:0] div;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    cur;
    logic [WIDTH-1:0]    head;
    logic [WIDTH:0]      sum;
    logic                full_c;
    logic                empty_c;
    logic                pop_c;

    assign sample_ready = !full_c;
    assign sample_tick  = en && (div == '1);
    // Empty is judged on the pre-push level, so a same-cycle push never bypasses.
    assign pop_c        = sample_tick && !empty_c;
    assign underrun     = sample_tick && empty_c;
    assign sum          = {1'b0, acc} + {1'b0, cur};

    sample_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (sample_valid),
        .data_in (sample_in),
        .pop     (pop_c),
        .head    (head),
        .level   (fifo_level),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Sample-period divider; held at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (!en) begin
            div <= '0;
        end else begin
            div <= div + OSR_LOG2'(1);
        end
    end

    // Current sample; retained through underruns and disable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
        end else if (pop_c) begin
            cur <= head;
        end
    end

    // First-order modulator: carry out of the accumulator is the output bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            dac_out <= 1'b0;
        end else if (!en) begin
            acc     <= '0;
            dac_out <= 1'b0;
        end else begin
            acc     <= sum[WIDTH-1:0];
            dac_out <= sum[WIDTH];
        end
    end

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Self-checking bench for sigma_delta_dac (WIDTH=8, OSR_LOG2=5, DEPTH_LOG2=2).
module tb_sigma_delta_dac;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned OSR_LOG2   = 5;
    localparam int unsigned DEPTH_LOG2 = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [WIDTH-1:0]    sample_in;
    logic                sample_valid;
    logic                sample_ready;
    logic                dac_out;
    logic                sample_tick;
    logic                underrun;
    logic [DEPTH_LOG2:0] fifo_level;

    int errors = 0;
    int checks = 0;

    // Scoreboard: samples accepted, in order, awaiting their tick.
    logic [WIDTH-1:0] exp_q [$];
    logic             cur_pending = 1'b0;
    logic [WIDTH-1:0] cur_exp;

    sigma_delta_dac #(
        .WIDTH      (WIDTH),
        .OSR_LOG2   (OSR_LOG2),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .dac_out      (dac_out),
        .sample_tick  (sample_tick),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur_pending = 1'b0;
        end else begin
            if (cur_pending) begin
                checks++;
                if (dut.cur !== cur_exp) begin
                    errors++;
                    $display("FAIL sb_cur: got %h expected %h", dut.cur, cur_exp);
                end
                cur_pending = 1'b0;
            end
            if (sample_tick) begin
                checks++;
                if (exp_q.size() == 0) begin
                    if (underrun !== 1'b1) begin
                        errors++;
                        $display("FAIL sb_underrun: got %b expected 1", underrun);
                    end
                end else begin
                    if (underrun !== 1'b0) begin
                        errors++;
                        $display("FAIL sb_underrun: got %b expected 0", underrun);
                    end
                    cur_exp     = exp_q.pop_front();
                    cur_pending = 1'b1;
                end
            end
            if (sample_valid && sample_ready) exp_q.push_back(sample_in);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Advance until just after the next tick edge.
    task automatic wait_tick();
        for (int i = 0; i < 200; i++) begin
            if (sample_tick) begin
                cycle();
                return;
            end
            cycle();
        end
        checks++;
        errors++;
        $display("FAIL wait_tick: got no tick expected tick within 200 cycles");
    endtask

    task automatic push_sample(input logic [WIDTH-1:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (sample_ready) begin
                cycle();
                sample_valid = 1'b0;
                return;
            end
            cycle();
        end
        sample_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL push_timeout: got ready=0 expected ready=1 within 200 cycles");
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            ones += int'(dac_out);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_in = '0;
        #1;
        checks++;
        if (fifo_level !== '0 || sample_ready !== 1'b1 || dac_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: got level=%0d ready=%b dac=%b expected 0 1 0",
                     fifo_level, sample_ready, dac_out);
        end
        repeat (2) cycle();
        rst = 1'b0;
        en  = 1'b1;
        wait_tick();
        push_sample(8'hFF);
        wait_tick();
        push_sample(8'h01);
        push_sample(8'h02);
        push_sample(8'h03);
        checks++;
        if (fifo_level !== 3'd3) begin
            errors++;
            $display("FAIL reset_prefill: got level=%0d expected 3", fifo_level);
        end
        for (int i = 0; i < 20; i++) begin
            if (dac_out) break;
            cycle();
        end
        checks++;
        if (dac_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_dac: got %b expected 1", dac_out);
        end
        // Assert reset mid-cycle; effects are immediate.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (fifo_level !== '0 || dac_out !== 1'b0 || sample_ready !== 1'b1 ||
            sample_tick !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got level=%0d dac=%b ready=%b tick=%b und=%b expected 0 0 1 0 0",
                     fifo_level, dac_out, sample_ready, sample_tick, underrun);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            if (k < 32) begin
                if (sample_tick !== 1'b0 || underrun !== 1'b0) bad++;
            end else begin
                checks++;
                if (sample_tick !== 1'b1 || underrun !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_first_tick: got tick=%b und=%b expected 1 1 at cycle 32",
                             sample_tick, underrun);
                end
            end
            cycle();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_quiet: got %0d early tick/underrun cycles expected 0", bad);
        end
    endtask

    task automatic test_density();
        int ones;
        int last;
        int bad_gap;
        push_sample(8'h40);
        wait_tick();
        cycle();
        ones = 0; last = -1; bad_gap = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            if (dac_out) begin
                ones++;
                if (last >= 0 && (i - last) != 4) bad_gap++;
                last = i;
            end
        end
        checks++;
        if (ones != 64) begin
            errors++;
            $display("FAIL density_40: got %0d ones expected 64", ones);
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL density_spacing: got %0d irregular gaps expected 0", bad_gap);
        end
    endtask

    task automatic test_extremes();
        int ones;
        wait_tick();
        push_sample(8'h00);
        push_sample(8'hFF);
        wait_tick();
        count_ones(32, ones);
        checks++;
        if (ones != 0) begin
            errors++;
            $display("FAIL extreme_00: got %0d ones expected 0", ones);
        end
        count_ones(256, ones);
        checks++;
        if (ones != 255) begin
            errors++;
            $display("FAIL extreme_ff: got %0d ones expected 255", ones);
        end
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] vals [5];
        int  idx;
        int  tick_c;
        int  acc5_c;
        bit  saw_full;
        bit  accepted;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h80;
        wait_tick();
        idx = 0; tick_c = -1; acc5_c = -2; saw_full = 1'b0;
        sample_valid = 1'b1;
        sample_in    = vals[0];
        for (int c = 0; c < 80 && idx < 5; c++) begin
            if (idx == 4 && !saw_full) begin
                saw_full = 1'b1;
                checks++;
                if (fifo_level !== 3'd4 || sample_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_flag: got level=%0d ready=%b expected 4 0",
                             fifo_level, sample_ready);
                end
            end
            if (sample_tick) tick_c = c;
            accepted = sample_ready;
            cycle();
            if (accepted) begin
                idx++;
                if (idx == 5) begin
                    acc5_c       = c;
                    sample_valid = 1'b0;
                end else begin
                    sample_in = vals[idx];
                end
            end
        end
        sample_valid = 1'b0;
        checks++;
        if (acc5_c != tick_c + 1) begin
            errors++;
            $display("FAIL full_reaccept: got 5th accept at %0d expected %0d", acc5_c, tick_c + 1);
        end
        checks++;
        if (fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL full_level_after: got %0d expected 4", fifo_level);
        end
    endtask

    task automatic test_underrun();
        int  ones;
        bit  done;
        repeat (4) wait_tick();
        checks++;
        if (fifo_level !== '0 || dut.cur !== 8'h80) begin
            errors++;
            $display("FAIL underrun_setup: got level=%0d cur=%h expected 0 80", fifo_level, dut.cur);
        end
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (sample_tick) begin
                checks++;
                if (underrun !== 1'b1) begin
                    errors++;
                    $display("FAIL underrun_pulse: got %b expected 1", underrun);
                end
                cycle();
                checks++;
                if (dut.cur !== 8'h80) begin
                    errors++;
                    $display("FAIL underrun_hold: got %h expected 80", dut.cur);
                end
                done = 1'b1;
            end else begin
                cycle();
            end
        end
        count_ones(256, ones);
        checks++;
        if (ones != 128) begin
            errors++;
            $display("FAIL underrun_density: got %0d ones expected 128", ones);
        end
        // Push coinciding with an empty-FIFO tick.
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (sample_tick) begin
                sample_valid = 1'b1;
                sample_in    = 8'hC0;
                checks++;
                if (underrun !== 1'b1) begin
                    errors++;
                    $display("FAIL nobypass_underrun: got %b expected 1", underrun);
                end
                cycle();
                sample_valid = 1'b0;
                checks++;
                if (fifo_level !== 3'd1 || dut.cur !== 8'h80) begin
                    errors++;
                    $display("FAIL nobypass_state: got level=%0d cur=%h expected 1 80",
                             fifo_level, dut.cur);
                end
                done = 1'b1;
            end else begin
                cycle();
            end
        end
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (sample_tick) begin
                checks++;
                if (underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL nobypass_next_und: got %b expected 0", underrun);
                end
                cycle();
                checks++;
                if (dut.cur !== 8'hC0) begin
                    errors++;
                    $display("FAIL nobypass_load: got %h expected c0", dut.cur);
                end
                done = 1'b1;
            end else begin
                cycle();
            end
        end
    endtask

    task automatic test_enable();
        int bad;
        int first;
        wait_tick();
        en  = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            sample_valid = (i == 2 || i == 5);
            sample_in    = (i == 2) ? 8'h5A : 8'hA5;
            cycle();
            sample_valid = 1'b0;
            if (dac_out !== 1'b0 || sample_tick !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL disable_quiet: got %0d active cycles expected 0", bad);
        end
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL disable_push: got level=%0d expected 2", fifo_level);
        end
        en    = 1'b1;
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            if (sample_tick) begin
                first = k;
                break;
            end
            cycle();
        end
        checks++;
        if (first != 32) begin
            errors++;
            $display("FAIL reenable_tick: got first tick at %0d expected 32", first);
        end
        cycle();
        checks++;
        if (dut.cur !== 8'h5A || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL reenable_order1: got cur=%h level=%0d expected 5a 1", dut.cur, fifo_level);
        end
        wait_tick();
        checks++;
        if (dut.cur !== 8'hA5 || fifo_level !== '0) begin
            errors++;
            $display("FAIL reenable_order2: got cur=%h level=%0d expected a5 0", dut.cur, fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_density();
        test_extremes();
        test_full();
        test_underrun();
        test_enable();
        repeat (2) cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
